// File: rtl/bist_pkg.sv
// Shared types and helpers for the multi-chain scan BIST controller.
// Holds the FSM state type, default LFSR constants and the LFSR step.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_COMPARE,
    ST_DONE
  } bist_state_t;

  localparam int LFSR_MAXW = 64;

  localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] DEF_MISR_POLY = 16'h8016;

  // left=0: right-shifting Galois PRPG, feedback from bit 0.
  // left=1: left-shifting MISR, feedback from bit w-1.
  function automatic logic [LFSR_MAXW-1:0] lfsr_step(
    input logic [LFSR_MAXW-1:0] s,
    input logic [LFSR_MAXW-1:0] poly,
    input logic [LFSR_MAXW-1:0] din,
    input int                   w,
    input logic                 left
  );
    logic [LFSR_MAXW-1:0] r;
    logic [LFSR_MAXW-1:0] m;
    logic                 fb;
    m  = {LFSR_MAXW{1'b1}} >> (LFSR_MAXW - w);
    fb = left ? |(s & (LFSR_MAXW'(1) << (w - 1)))
              : s[0];
    r  = left ? (s << 1) : (s >> 1);
    if (fb) r = r ^ poly;
    return (r ^ din) & m;
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Galois LFSR register with seed load and parallel data injection.
// Used both as the pattern generator and as the signature register.
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] POLY = DEF_LFSR_POLY,
  parameter logic [W-1:0] SEED = DEF_LFSR_SEED,
  parameter bit           LEFT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_nxt;

  assign w_nxt = W'(lfsr_step(
    LFSR_MAXW'(r_q),
    LFSR_MAXW'(POLY),
    LFSR_MAXW'(i_din),
    W,
    LEFT
  ));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= SEED;
    end else if (i_load) begin
      r_q <= SEED;
    end else if (i_en) begin
      r_q <= w_nxt;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/scan_bist_ctrl.sv
// Multi-chain scan BIST controller: PRPG-driven load/capture loop,
// MISR compaction of chain outputs and a final signature compare.
module scan_bist_ctrl
  import bist_pkg::*;
#(
  parameter int                NCHAINS    = 4,
  parameter int                CHAIN_LEN  = 8,
  parameter int                NPATTERNS  = 8,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY  = DEF_LFSR_POLY,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = DEF_LFSR_SEED,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = DEF_MISR_POLY,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bistmode,
  input  logic [NCHAINS-1:0] cut_sdo,
  output logic               cut_scanmode,
  output logic [NCHAINS-1:0] cut_sdi,
  output logic               bistdone,
  output logic               bistpass,
  output logic [MISR_W-1:0]  bist_signature
);

  localparam int SW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(NPATTERNS + 1);

  bist_state_t r_state;
  bist_state_t w_next;

  logic [SW-1:0]     r_shcnt;
  logic [PW-1:0]     r_pcnt;
  logic              r_pass;
  logic              w_shift_last;
  logic              w_pat_last;
  logic              w_seed;
  logic              w_prpg_en;
  logic              w_misr_en;
  logic [LFSR_W-1:0] w_prpg;
  logic [MISR_W-1:0] w_misr;
  logic              w_unused;

  assign w_shift_last = r_shcnt == SW'(CHAIN_LEN - 1);
  assign w_pat_last   = r_pcnt == PW'(NPATTERNS - 1);

  // Idle or abort: everything returns to its start value
  assign w_seed    = (r_state == ST_IDLE) || !bistmode;
  assign w_prpg_en = r_state == ST_SHIFT;
  assign w_misr_en = (r_state == ST_UNLOAD) ||
                     ((r_state == ST_SHIFT) && (r_pcnt != '0));

  bist_lfsr #(
    .W    (LFSR_W),
    .POLY (LFSR_POLY),
    .SEED (LFSR_SEED),
    .LEFT (1'b0)
  ) u_prpg (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_prpg_en),
    .i_load (w_seed),
    .i_din  ('0),
    .o_q    (w_prpg)
  );

  bist_lfsr #(
    .W    (MISR_W),
    .POLY (MISR_POLY),
    .SEED ('0),
    .LEFT (1'b1)
  ) u_misr (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_misr_en),
    .i_load (w_seed),
    .i_din  (MISR_W'(cut_sdo)),
    .o_q    (w_misr)
  );

  assign w_unused = ^w_prpg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!bistmode) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:    w_next = ST_SHIFT;
        ST_SHIFT:   if (w_shift_last) w_next = ST_CAPTURE;
        ST_CAPTURE: w_next = w_pat_last ? ST_UNLOAD
                                        : ST_SHIFT;
        ST_UNLOAD:  if (w_shift_last) w_next = ST_COMPARE;
        ST_COMPARE: w_next = ST_DONE;
        ST_DONE:    w_next = ST_DONE;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shcnt <= '0;
      r_pcnt  <= '0;
      r_pass  <= 1'b0;
    end else if (w_seed) begin
      r_shcnt <= '0;
      r_pcnt  <= '0;
      r_pass  <= 1'b0;
    end else begin
      if ((r_state == ST_SHIFT) ||
          (r_state == ST_UNLOAD)) begin
        r_shcnt <= w_shift_last ? '0 : r_shcnt + 1'b1;
      end
      if (r_state == ST_CAPTURE) begin
        r_pcnt <= r_pcnt + 1'b1;
      end
      if (r_state == ST_COMPARE) begin
        r_pass <= w_misr == GOLDEN_SIG;
      end
    end
  end

  assign cut_scanmode   = (r_state == ST_SHIFT) ||
                          (r_state == ST_UNLOAD);
  assign cut_sdi        = (r_state == ST_SHIFT) ?
                          w_prpg[NCHAINS-1:0] : '0;
  assign bistdone       = r_state == ST_DONE;
  assign bistpass       = r_pass;
  assign bist_signature = w_misr;

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Self-checking bench for scan_bist_ctrl: default 4x8x8 build plus a
// minimal 1x1x1 build, each driven by a shift-register CUT model.
module tb_scan_bist_ctrl;

  localparam int NCH = 4;
  localparam int CL  = 8;
  localparam int NP  = 8;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [15:0] PPOLY = 16'hB400;
  localparam logic [15:0] MPOLY = 16'h8016;

  function automatic logic [15:0] prpg(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? PPOLY : 16'h0);
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] m);
    return (m << 1) ^ (m[15] ? MPOLY : 16'h0);
  endfunction

  // The chains delay the scan-in stream by the chain length, so the
  // MISR absorbs the first np*cl PRPG states, in order.
  function automatic logic [15:0] golden(input int nch,
                                         input int cl,
                                         input int np);
    logic [15:0] p;
    logic [15:0] m;
    logic [15:0] msk;
    p   = SEED;
    m   = 16'h0;
    msk = 16'((32'd1 << nch) - 1);
    for (int i = 0; i < np * cl; i++) begin
      m = misr(m) ^ (p & msk);
      p = prpg(p);
    end
    return m;
  endfunction

  localparam logic [15:0] GOLD   = golden(NCH, CL, NP);
  localparam logic [15:0] GOLD_S = golden(1, 1, 1);

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        reset;
  logic        bistmode;
  logic        bistmode_s;
  logic        stuck;

  logic              scan_b;
  logic [NCH-1:0]    sdi_b;
  logic [NCH-1:0]    sdo_b;
  logic              done_b;
  logic              pass_b;
  logic [15:0]       sig_b;

  logic              scan_s;
  logic [0:0]        sdi_s;
  logic [0:0]        sdo_s;
  logic              done_s;
  logic              pass_s;
  logic [15:0]       sig_s;

  logic [NCH-1:0][CL-1:0] ch_b = '0;
  logic                   ch_s = 1'b0;

  logic [15:0] pseq [0:127];
  bit          m_active = 1'b0;
  int          m_c = 0;
  int          n_pass = 0;
  int          n_tot = 0;

  scan_bist_ctrl #(
    .GOLDEN_SIG (GOLD)
  ) u_big (
    .clk            (clk),
    .reset          (reset),
    .bistmode       (bistmode),
    .cut_sdo        (sdo_b),
    .cut_scanmode   (scan_b),
    .cut_sdi        (sdi_b),
    .bistdone       (done_b),
    .bistpass       (pass_b),
    .bist_signature (sig_b)
  );

  scan_bist_ctrl #(
    .NCHAINS    (1),
    .CHAIN_LEN  (1),
    .NPATTERNS  (1),
    .GOLDEN_SIG (GOLD_S)
  ) u_small (
    .clk            (clk),
    .reset          (reset),
    .bistmode       (bistmode_s),
    .cut_sdo        (sdo_s),
    .cut_scanmode   (scan_s),
    .cut_sdi        (sdi_s),
    .bistdone       (done_s),
    .bistpass       (pass_s),
    .bist_signature (sig_s)
  );

  always #5 if (clk_en) clk = ~clk;

  // CUT: plain shift registers, capture leaves contents unchanged
  always @(posedge clk) begin
    if (scan_b) begin
      for (int i = 0; i < NCH; i++) begin
        ch_b[i] <= {ch_b[i][CL-2:0], sdi_b[i]};
      end
    end
    if (scan_s) ch_s <= sdi_s[0];
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) sdo_b[i] = ch_b[i][CL-1];
    if (stuck) sdo_b[2] = 1'b0;
    sdo_s[0] = ch_s;
  end

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, exp);
  endtask

  function automatic logic [15:0] fold(input int j, input bit stk);
    logic [15:0] m;
    logic [3:0]  d;
    m = 16'h0;
    for (int i = 0; i < j; i++) begin
      d = pseq[i][3:0] & (stk ? 4'b1011 : 4'b1111);
      m = misr(m) ^ {12'h0, d};
    end
    return m;
  endfunction

  // Expected {scanmode, sdi, done, pass, signature} in run cycle c
  function automatic logic [22:0] exp_at(input int c, input bit stk);
    int          k;
    int          r;
    int          scans;
    logic        scan;
    logic        dn;
    logic        ps;
    logic [3:0]  sdi;
    logic [15:0] sig;
    scan = 1'b0;
    sdi  = 4'h0;
    dn   = 1'b0;
    if (c < NP * (CL + 1)) begin
      k = c / (CL + 1);
      r = c % (CL + 1);
      if (r < CL) begin
        scan  = 1'b1;
        sdi   = pseq[k * CL + r][3:0];
        scans = k * CL + r;
      end else begin
        scans = (k + 1) * CL;
      end
    end else if (c < NP * (CL + 1) + CL) begin
      scan  = 1'b1;
      scans = NP * CL + c - NP * (CL + 1);
    end else begin
      scans = (NP + 1) * CL;
      dn    = c > NP * (CL + 1) + CL;
    end
    sig = fold(scans > CL ? scans - CL : 0, stk);
    ps  = dn && (sig == GOLD);
    return {scan, sdi, dn, ps, sig};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
    end else if (!bistmode) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      m_active <= 1'b1;
      m_c      <= 0;
    end else begin
      m_c <= m_c + 1;
    end
  end

  always @(negedge clk) begin
    check("cycle",
          {scan_b, sdi_b, done_b, pass_b, sig_b},
          m_active ? exp_at(m_c, stuck) : 23'h0);
  end

  task automatic measure(input bit sel,
                         output int lat,
                         output logic [15:0] nib);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    nib  = 16'h0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = sel ? scan_s : scan_b;
    end
    check("start_seen", seen, 1);
    for (int i = 0; i < 300 && seen; i++) begin
      if (i < 4) nib = {nib[11:0], sdi_b};
      if (sel ? done_s : done_b) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_run(input int k);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = scan_b;
    end
    check("run_seen", seen, 1);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int          lat;
    logic [15:0] nib;
    pseq[0] = SEED;
    for (int i = 1; i < 128; i++) pseq[i] = prpg(pseq[i-1]);
    reset      = 1'b1;
    bistmode   = 1'b0;
    bistmode_s = 1'b0;
    stuck      = 1'b0;
    #3;
    check("rst_noclk_b",
          {scan_b, sdi_b, done_b, pass_b, sig_b}, 0);
    check("rst_noclk_s",
          {scan_s, sdi_s, done_s, pass_s, sig_s}, 0);
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("idle10", {scan_b, sdi_b, done_b, pass_b, sig_b}, 0);

    bistmode = 1'b1;
    measure(1'b0, lat, nib);
    check("run_len", lat, 81);
    check("prpg_first4", nib, 16'h108C);
    check("pass", pass_b, 1);
    check("sig", sig_b, GOLD);
    repeat (3) @(negedge clk);
    bistmode = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    stuck    = 1'b1;
    bistmode = 1'b1;
    measure(1'b0, lat, nib);
    check("stuck_len", lat, 81);
    check("stuck_pass", pass_b, 0);
    check("stuck_sig_differs", sig_b != GOLD, 1);
    bistmode = 1'b0;
    repeat (3) @(posedge clk);
    #1 stuck = 1'b0;

    bistmode = 1'b1;
    wait_run(30);
    bistmode = 1'b0;
    @(posedge clk);
    #1;
    check("abort", {scan_b, done_b, pass_b, sig_b}, 0);
    repeat (2) @(posedge clk);
    #1 bistmode = 1'b1;
    measure(1'b0, lat, nib);
    check("rerun_len", lat, 81);
    check("rerun_pass", pass_b, 1);
    check("rerun_sig", sig_b, GOLD);
    bistmode = 1'b0;
    repeat (3) @(posedge clk);
    #1 bistmode = 1'b1;

    wait_run(75);
    #1 reset = 1'b1;
    #1;
    check("async_rst",
          {scan_b, sdi_b, done_b, pass_b, sig_b}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    measure(1'b0, lat, nib);
    check("rst_rerun_len", lat, 81);
    check("rst_rerun_pass", pass_b, 1);
    bistmode = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    bistmode_s = 1'b1;
    measure(1'b1, lat, nib);
    check("small_len", lat, 4);
    check("small_pass", pass_s, 1);
    check("small_sig", sig_s, 16'h0001);
    repeat (20) begin
      @(posedge clk);
      #1;
      check("small_hold", {done_s, pass_s}, 2'b11);
    end
    bistmode_s = 1'b0;
    @(posedge clk);
    #1;
    check("small_clear", {done_s, pass_s}, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
